// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the four-channel TDM demultiplexer.
//   NUM_SLOTS      - slots per frame
//   slot_t         - 2-bit slot index {s1,s0}
//   state_t        - framing state (HUNT until a frame_sync is seen, then LOCKED)
//   SLOT_A..SLOT_D - slot indices for channels a..d
package tdm_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam slot_t SLOT_A = 2'd0;
  localparam slot_t SLOT_B = 2'd1;
  localparam slot_t SLOT_C = 2'd2;
  localparam slot_t SLOT_D = slot_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with wrap-around.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (slot returns to 0)
//   adv        - advance one slot, 3 wraps to 0
//   load1      - force slot to 1 (a slot-0 sample was just captured)
//   clr        - force slot to 0 (framing lost)
//   slot       - current expected slot
//   last       - slot is the final slot of the frame
// Priority when several controls are high: clr, then load1, then adv.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  input  logic  load1,
  input  logic  clr,
  output slot_t slot,
  output logic  last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_A;
    end else if (clr) begin
      slot <= SLOT_A;
    end else if (load1) begin
      slot <= SLOT_B;
    end else if (adv) begin
      slot <= slot + 2'd1;
    end
  end

  assign last = (slot == SLOT_D);

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-channel time-division demultiplexer (receive end of a
// 4:1 select-multiplexed link).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   din, din_valid      - serialized sample and its qualifier
//   frame_sync          - marks din as slot 0 (only meaningful with din_valid)
//   out_a..out_d        - registered channel samples for slots 0..3
//   frame_valid         - one-cycle pulse: out_a..out_d hold a new frame
//   locked              - framing state is LOCKED
//   sync_err            - one-cycle pulse on a framing violation
//   slot                - slot index expected for the next valid sample
//   err_cnt             - saturating count of sync_err pulses
//                         (present only when TDM_DEMUX_ERR_CNT_EN is defined)
// Handshake: din is consumed on every rising edge where din_valid=1; there is
// no back-pressure, and cycles with din_valid=0 change nothing.
// Slots 0..2 land in capture registers; the slot-3 sample goes straight to
// out_d together with the captured ones, so partial frames never reach the
// outputs.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int SYNC_EVERY_FRAME = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       slot
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cap_a, cap_b, cap_c;
  logic             cap_a_en, cap_b_en, cap_c_en;
  logic             frame_done, err;
  logic             ctr_adv, ctr_load1, ctr_clr, ctr_last;
  slot_t            slot_q;

  tdm_slot_ctr u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (ctr_adv),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot_q),
    .last  (ctr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_a_en   = 1'b0;
    cap_b_en   = 1'b0;
    cap_c_en   = 1'b0;
    frame_done = 1'b0;
    err        = 1'b0;
    ctr_adv    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_clr    = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            cap_a_en  = 1'b1;
            ctr_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && (slot_q != SLOT_A)) begin
            // Early sync: drop the partial frame and re-align on this sample.
            err       = 1'b1;
            cap_a_en  = 1'b1;
            ctr_load1 = 1'b1;
          end else if (slot_q == SLOT_A) begin
            if (frame_sync || (SYNC_EVERY_FRAME == 0)) begin
              cap_a_en  = 1'b1;
              ctr_load1 = 1'b1;
            end else begin
              err     = 1'b1;
              ctr_clr = 1'b1;
              state_d = HUNT;
            end
          end else if (ctr_last) begin
            frame_done = 1'b1;
            ctr_adv    = 1'b1;
          end else begin
            cap_b_en = (slot_q == SLOT_B);
            cap_c_en = (slot_q == SLOT_C);
            ctr_adv  = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_a       <= '0;
      cap_b       <= '0;
      cap_c       <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_d       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (cap_a_en) cap_a <= din;
      if (cap_b_en) cap_b <= din;
      if (cap_c_en) cap_c <= din;
      if (frame_done) begin
        out_a <= cap_a;
        out_b <= cap_b;
        out_c <= cap_c;
        out_d <= din;
      end
      frame_valid <= frame_done;
      sync_err    <= err;
    end
  end

  assign locked = (state_q == LOCKED);
  assign slot   = slot_q;

`ifdef TDM_DEMUX_ERR_CNT_EN
  // Counts the violation on the same edge that raises sync_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: bench for tdm_demux4. Two instances share the stimulus:
// index 0 uses SYNC_EVERY_FRAME=1, index 1 uses SYNC_EVERY_FRAME=0.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;

  logic [7:0] oa[2], ob[2], oc[2], od[2];
  logic       fv[2], lk[2], se[2];
  logic [1:0] sl[2];
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] ec[2];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(8), .SYNC_EVERY_FRAME(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]), .out_d(od[0]),
    .frame_valid(fv[0]), .locked(lk[0]), .sync_err(se[0]), .slot(sl[0])
`ifdef TDM_DEMUX_ERR_CNT_EN
    , .err_cnt(ec[0])
`endif
  );

  tdm_demux4 #(.WIDTH(8), .SYNC_EVERY_FRAME(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]), .out_d(od[1]),
    .frame_valid(fv[1]), .locked(lk[1]), .sync_err(se[1]), .slot(sl[1])
`ifdef TDM_DEMUX_ERR_CNT_EN
    , .err_cnt(ec[1])
`endif
  );

  // ---------------- reference model (frame assembled in a small array) ----
  int         sef[2] = '{1, 0};
  logic       m_lk[2];
  int         m_n[2];          // samples collected in the current frame
  logic [7:0] m_buf[2][4];
  logic [31:0] m_out[2];
  logic       m_fv[2], m_se[2];
  int         m_err[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lk[i] = 1'b0; m_n[i] = 0; m_out[i] = 32'd0;
      m_fv[i] = 1'b0; m_se[i] = 1'b0; m_err[i] = 0;
      for (int k = 0; k < 4; k++) m_buf[i][k] = 8'd0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic s, input logic [7:0] d);
    m_fv[i] = 1'b0;
    m_se[i] = 1'b0;
    if (v) begin
      if (!m_lk[i]) begin
        if (s) begin
          m_lk[i] = 1'b1; m_buf[i][0] = d; m_n[i] = 1;
        end
      end else if (s && m_n[i] != 0) begin
        m_se[i] = 1'b1; m_buf[i][0] = d; m_n[i] = 1;
      end else if (!s && m_n[i] == 0 && sef[i] == 1) begin
        m_se[i] = 1'b1; m_lk[i] = 1'b0;
      end else begin
        m_buf[i][m_n[i]] = d;
        m_n[i] = m_n[i] + 1;
        if (m_n[i] == 4) begin
          m_out[i] = {m_buf[i][0], m_buf[i][1], m_buf[i][2], m_buf[i][3]};
          m_fv[i]  = 1'b1;
          m_n[i]   = 0;
        end
      end
      if (m_se[i] && m_err[i] < 255) m_err[i] = m_err[i] + 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fv_d%0d", i), 32'(fv[i]), 32'(m_fv[i]));
      chk($sformatf("se_d%0d", i), 32'(se[i]), 32'(m_se[i]));
      chk($sformatf("lk_d%0d", i), 32'(lk[i]), 32'(m_lk[i]));
      chk($sformatf("slot_d%0d", i), 32'(sl[i]), 32'(m_n[i]));
      chk($sformatf("outs_d%0d", i), {oa[i], ob[i], oc[i], od[i]}, m_out[i]);
`ifdef TDM_DEMUX_ERR_CNT_EN
      chk($sformatf("errcnt_d%0d", i), 32'(ec[i]), 32'(m_err[i]));
`endif
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, v, s, d);
    chk_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_outs"}, {oa[i], ob[i], oc[i], od[i]}, 32'd0);
      chk({tag, "_fv"}, 32'(fv[i]), 32'd0);
      chk({tag, "_se"}, 32'(se[i]), 32'd0);
      chk({tag, "_lk"}, 32'(lk[i]), 32'd0);
      chk({tag, "_slot"}, 32'(sl[i]), 32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
      chk({tag, "_errcnt"}, 32'(ec[i]), 32'd0);
`endif
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0; frame_sync = 1'b0; din = 8'd0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table (checked against dut0, SYNC_EVERY_FRAME=1) ----
  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        fv;
    logic        se;
    logic        lk;
    logic [1:0]  sl;
    logic [31:0] outs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic f, logic e,
                              logic l, logic [1:0] sl_e, logic [31:0] o);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.fv = f; t.se = e; t.lk = l; t.sl = sl_e; t.outs = o;
    return t;
  endfunction

  initial begin
    logic s_r;
    // basic frame
    tbl.push_back(mk(1, 1, 8'h11, 0, 0, 1, 1, 32'h0));
    tbl.push_back(mk(1, 0, 8'h22, 0, 0, 1, 2, 32'h0));
    tbl.push_back(mk(1, 0, 8'h33, 0, 0, 1, 3, 32'h0));
    tbl.push_back(mk(1, 0, 8'h44, 1, 0, 1, 0, 32'h11223344));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 32'h11223344));
    // slot 0 without sync: error, back to HUNT, outputs keep the frame
    tbl.push_back(mk(1, 0, 8'h55, 0, 1, 0, 0, 32'h11223344));
    // HUNT discards unsynced samples
    tbl.push_back(mk(1, 0, 8'h66, 0, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'h77, 0, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'h88, 0, 0, 0, 0, 32'h11223344));
    tbl.push_back(mk(1, 1, 8'hA0, 0, 0, 1, 1, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'hA1, 0, 0, 1, 2, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'hA2, 0, 0, 1, 3, 32'h11223344));
    tbl.push_back(mk(1, 0, 8'hA3, 1, 0, 1, 0, 32'hA0A1A2A3));
    // two idle cycles between samples 2 and 3
    tbl.push_back(mk(1, 1, 8'h01, 0, 0, 1, 1, 32'hA0A1A2A3));
    tbl.push_back(mk(1, 0, 8'h02, 0, 0, 1, 2, 32'hA0A1A2A3));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 2, 32'hA0A1A2A3));
    tbl.push_back(mk(0, 0, 8'hEE, 0, 0, 1, 2, 32'hA0A1A2A3));
    tbl.push_back(mk(1, 0, 8'h03, 0, 0, 1, 3, 32'hA0A1A2A3));
    tbl.push_back(mk(1, 0, 8'h04, 1, 0, 1, 0, 32'h01020304));
    // early sync re-aligns
    tbl.push_back(mk(1, 1, 8'h01, 0, 0, 1, 1, 32'h01020304));
    tbl.push_back(mk(1, 0, 8'h02, 0, 0, 1, 2, 32'h01020304));
    tbl.push_back(mk(1, 1, 8'h10, 0, 1, 1, 1, 32'h01020304));
    tbl.push_back(mk(1, 0, 8'h11, 0, 0, 1, 2, 32'h01020304));
    tbl.push_back(mk(1, 0, 8'h12, 0, 0, 1, 3, 32'h01020304));
    tbl.push_back(mk(1, 0, 8'h13, 1, 0, 1, 0, 32'h10111213));
    // early sync on the last slot
    tbl.push_back(mk(1, 1, 8'h20, 0, 0, 1, 1, 32'h10111213));
    tbl.push_back(mk(1, 0, 8'h21, 0, 0, 1, 2, 32'h10111213));
    tbl.push_back(mk(1, 0, 8'h22, 0, 0, 1, 3, 32'h10111213));
    tbl.push_back(mk(1, 1, 8'h30, 0, 1, 1, 1, 32'h10111213));

    do_reset();

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].v, tbl[k].s, tbl[k].d);
      chk($sformatf("tbl%0d_fv", k), 32'(fv[0]), 32'(tbl[k].fv));
      chk($sformatf("tbl%0d_se", k), 32'(se[0]), 32'(tbl[k].se));
      chk($sformatf("tbl%0d_lk", k), 32'(lk[0]), 32'(tbl[k].lk));
      chk($sformatf("tbl%0d_slot", k), 32'(sl[0]), 32'(tbl[k].sl));
      chk($sformatf("tbl%0d_outs", k), {oa[0], ob[0], oc[0], od[0]}, tbl[k].outs);
    end
`ifdef TDM_DEMUX_ERR_CNT_EN
    // 0x55 missing sync, 0x10 and 0x30 early syncs
    chk("tbl_errcnt_d0", 32'(ec[0]), 32'd3);
`endif

    // SYNC_EVERY_FRAME=0 instance: second frame without sync is a normal frame
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, k == 0, 8'(8'h40 + k));
    chk("nosync_d1_outs", {oa[1], ob[1], oc[1], od[1]}, 32'h44454647);
    chk("nosync_d1_lk", 32'(lk[1]), 32'd1);
    chk("nosync_d0_outs", {oa[0], ob[0], oc[0], od[0]}, 32'h40414243);
    chk("nosync_d0_lk", 32'(lk[0]), 32'd0);

    // continuous frames, then asynchronous reset mid-frame
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, (k % 4) == 1, 8'(k));
      chk($sformatf("cont%0d_fv", k), 32'(fv[0]), 32'((k % 4) == 0));
    end
    chk("cont_outs", {oa[0], ob[0], oc[0], od[0]}, 32'h05060708);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    din_valid = 1'b0; frame_sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk_model();

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (m_n[0] == 0) s_r = ($urandom_range(0, 9) != 0);
      else             s_r = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 3) != 0, s_r, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
